// File: rtl/scram_frame_ctrl_pkg.sv
// Shared state encoding and constants for the DATA-field scrambler sequencer.
package scram_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SERVICE,
    ST_PSDU,
    ST_TAIL,
    ST_PAD,
    ST_DONE
  } frame_state_t;

  localparam int         SERVICE_BITS = 16;
  localparam int         TAIL_BITS    = 6;
  localparam logic [3:0] BYTE_BITS    = 4'd8;
  localparam logic [6:0] DEF_SEED     = 7'b1011101;

  localparam logic [7:0] NDBPS_LEGAL [8] = '{8'd24, 8'd36, 8'd48, 8'd72,
                                             8'd96, 8'd144, 8'd192, 8'd216};

  // An unconfigured symbol size falls back to the smallest legal rate.
  function automatic logic [7:0] ndbps_or_default(input logic [7:0] n);
    return (n == 8'd0) ? NDBPS_LEGAL[0] : n;
  endfunction

  function automatic logic [6:0] seed_or_default(input logic [6:0] s, input logic [6:0] def);
    return (s == 7'd0) ? def : s;
  endfunction

endpackage

// File: rtl/psdu_byte_serializer.sv
// Byte-to-bit serializer for the PSDU: one byte register drained LSB-first.
// Refetches in the same cycle the last held bit is taken, so a steady source sees no bubbles.
module psdu_byte_serializer
  import scram_frame_ctrl_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clear,
  input  logic             fetch_en,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             bit_take,
  output logic             bit_vld,
  output logic             bit_dat,
  output logic             bit_last
);

  logic [7:0]       shreg;
  logic [3:0]       bcnt;
  logic [LEN_W-1:0] fetched;

  assign bit_vld    = (bcnt != 4'd0);
  assign bit_dat    = shreg[0];
  assign bit_last   = (bcnt == 4'd1) && (fetched == len);
  assign byte_ready = fetch_en && (fetched < len) &&
                      ((bcnt == 4'd0) || ((bcnt == 4'd1) && bit_take));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      shreg   <= 8'd0;
      bcnt    <= 4'd0;
      fetched <= '0;
    end else if (byte_valid && byte_ready) begin
      shreg   <= byte_data;
      bcnt    <= BYTE_BITS;
      fetched <= fetched + 1'b1;
    end else if (bit_take && bit_vld) begin
      shreg <= {1'b0, shreg[7:1]};
      bcnt  <= bcnt - 4'd1;
    end
  end

endmodule

// File: rtl/scram_frame_ctrl.sv
// Sequences seed load, SERVICE, PSDU, tail and pad bits into the scrambler.
// Tail/sym-last flags are delayed one extra register to line up with the scrambler's dout.
module scram_frame_ctrl
  import scram_frame_ctrl_pkg::*;
#(
  parameter logic [6:0] DEF_SEED = scram_frame_ctrl_pkg::DEF_SEED,
  parameter int         LEN_W    = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [7:0]       cfg_ndbps,
  input  logic [6:0]       cfg_seed,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [6:0]       scram_seed,
  output logic             scram_load,
  output logic             scram_din,
  output logic             scram_valid_i,
  output logic             tail_o,
  output logic             sym_last_o,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] SERVICE_LAST = 5'(SERVICE_BITS - 1);
  localparam logic [4:0] TAIL_LAST    = 5'(TAIL_BITS - 1);
  localparam logic [4:0] DONE_LAST    = 5'd2;

  frame_state_t     state, state_n;
  logic [LEN_W-1:0] len_r;
  logic [7:0]       ndbps_r;
  logic [7:0]       sym_cnt;
  logic [4:0]       ph_cnt, ph_n;
  logic             emit, din_c, tail_c, last_c, take, sym_wrap;
  logic             tail_d, last_d;
  logic             ser_vld, ser_dat, ser_last;

  assign sym_wrap = (sym_cnt == ndbps_r - 8'd1);
  assign last_c   = emit && sym_wrap;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE) && (ph_cnt == DONE_LAST);

  psdu_byte_serializer #(.LEN_W(LEN_W)) u_ser (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .clear      (state == ST_IDLE),
    .fetch_en   ((state == ST_SERVICE) || (state == ST_PSDU)),
    .len        (len_r),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .bit_take   (take),
    .bit_vld    (ser_vld),
    .bit_dat    (ser_dat),
    .bit_last   (ser_last)
  );

  always_comb begin
    state_n = state;
    ph_n    = ph_cnt;
    emit    = 1'b0;
    din_c   = 1'b0;
    tail_c  = 1'b0;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        ph_n    = 5'd0;
        state_n = ST_SERVICE;
      end
      ST_SERVICE: begin
        emit = 1'b1;
        ph_n = ph_cnt + 5'd1;
        if (ph_cnt == SERVICE_LAST) begin
          ph_n    = 5'd0;
          state_n = (len_r == '0) ? ST_TAIL : ST_PSDU;
        end
      end
      ST_PSDU: begin
        // An empty register is an underrun: nothing is emitted and sym_cnt holds.
        if (ser_vld) begin
          emit  = 1'b1;
          take  = 1'b1;
          din_c = ser_dat;
          if (ser_last) state_n = ST_TAIL;
        end
      end
      ST_TAIL: begin
        emit   = 1'b1;
        tail_c = 1'b1;
        ph_n   = ph_cnt + 5'd1;
        if (ph_cnt == TAIL_LAST) begin
          ph_n    = 5'd0;
          state_n = sym_wrap ? ST_DONE : ST_PAD;
        end
      end
      ST_PAD: begin
        emit = 1'b1;
        if (sym_wrap) state_n = ST_DONE;
      end
      ST_DONE: begin
        // Two cycles for the last bit to reach the scrambler output, then the done pulse.
        ph_n = ph_cnt + 5'd1;
        if (ph_cnt == DONE_LAST) begin
          ph_n    = 5'd0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        ph_n    = 5'd0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      ph_cnt        <= 5'd0;
      len_r         <= '0;
      ndbps_r       <= 8'd0;
      sym_cnt       <= 8'd0;
      scram_seed    <= 7'd0;
      scram_load    <= 1'b0;
      scram_din     <= 1'b0;
      scram_valid_i <= 1'b0;
      tail_d        <= 1'b0;
      last_d        <= 1'b0;
      tail_o        <= 1'b0;
      sym_last_o    <= 1'b0;
    end else begin
      state  <= state_n;
      ph_cnt <= ph_n;
      if (state == ST_IDLE && start) begin
        len_r      <= cfg_len;
        ndbps_r    <= ndbps_or_default(cfg_ndbps);
        scram_seed <= seed_or_default(cfg_seed, DEF_SEED);
      end
      if (state == ST_IDLE)
        sym_cnt <= 8'd0;
      else if (emit)
        sym_cnt <= sym_wrap ? 8'd0 : sym_cnt + 8'd1;
      scram_load    <= (state == ST_LOAD);
      scram_valid_i <= emit;
      scram_din     <= din_c;
      tail_d        <= tail_c;
      last_d        <= last_c;
      tail_o        <= tail_d;
      sym_last_o    <= last_d;
    end
  end

endmodule

// File: tb/tb_scram_frame_ctrl.sv
// Directed bench for scram_frame_ctrl: per-bit scoreboard of din/tail/sym-last at the
// scrambler-output alignment, plus done latency, bubbles, seed and reset checks.
module tb_scram_frame_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [11:0] cfg_len;
  logic [7:0]  cfg_ndbps;
  logic [6:0]  cfg_seed;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [6:0]  scram_seed;
  logic        scram_load, scram_din, scram_valid_i, tail_o, sym_last_o, busy, done;

  always #5 sys_clk = ~sys_clk;

  scram_frame_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cfg_len(cfg_len),
    .cfg_ndbps(cfg_ndbps), .cfg_seed(cfg_seed), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .scram_seed(scram_seed),
    .scram_load(scram_load), .scram_din(scram_din), .scram_valid_i(scram_valid_i),
    .tail_o(tail_o), .sym_last_o(sym_last_o), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic din;
    logic tail;
    logic last;
  } exp_bit_t;

  exp_bit_t   exp_q[$];
  logic [7:0] src_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, out_cnt = 0, frame_bits = 0, gap_seen = 0, ready_seen = 0, loads_seen = 0;
  int last_out_cyc = -100, pops = 0, gap_after = 0, gap_len = 0, gap_cnt = 0;
  bit gap_arm = 0, mon_en = 0, xfer_pend = 0;
  logic prev_valid = 0, prev_din = 0;
  logic [6:0] exp_seed = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score the output-aligned bit, then drive the byte source.
  task automatic tick();
    exp_bit_t e;
    @(negedge sys_clk);
    cyc++;
    if (xfer_pend) begin
      void'(src_q.pop_front());
      pops++;
    end
    if (mon_en) begin
      if (prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bit_din", prev_din, e.din);
          chk("bit_tail", tail_o, e.tail);
          chk("bit_symlast", sym_last_o, e.last);
          out_cnt++;
          last_out_cyc = cyc;
        end
      end else begin
        chk("flags_idle", {tail_o, sym_last_o}, 0);
        if (out_cnt > 0 && out_cnt < frame_bits) gap_seen++;
      end
      if (scram_load) begin
        loads_seen++;
        chk("load_seed", scram_seed, exp_seed);
        chk("load_no_valid", scram_valid_i, 0);
      end
      if (byte_ready) ready_seen++;
    end
    prev_valid = scram_valid_i;
    prev_din   = scram_din;
    if (gap_arm && pops == gap_after && byte_ready) begin
      gap_cnt = gap_len;
      gap_arm = 0;
    end
    if (gap_cnt > 0) begin
      byte_valid = 1'b0;
      gap_cnt--;
    end else begin
      byte_valid = (src_q.size() > 0);
      byte_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
    xfer_pend = byte_valid && byte_ready;
  endtask

  task automatic launch(input int len, input int ndbps, input logic [6:0] seed,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bt [3];
    exp_bit_t   e;
    int ndb, nb, total, k;
    bt[0] = b0; bt[1] = b1; bt[2] = b2;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) src_q.push_back(bt[i]);
    ndb   = (ndbps == 0) ? 24 : ndbps;
    nb    = 22 + 8 * len;
    total = ((nb + ndb - 1) / ndb) * ndb;
    for (int i = 0; i < total; i++) begin
      k      = i - 16;
      e.din  = (i >= 16 && i < 16 + 8 * len) ? bt[k / 8][k % 8] : 1'b0;
      e.tail = (i >= 16 + 8 * len && i < nb);
      e.last = ((i % ndb) == ndb - 1);
      exp_q.push_back(e);
    end
    frame_bits   = total;
    out_cnt      = 0;
    gap_seen     = 0;
    ready_seen   = 0;
    loads_seen   = 0;
    pops         = 0;
    last_out_cyc = -100;
    exp_seed     = (seed == 7'd0) ? 7'b1011101 : seed;
    cfg_len      = 12'(len);
    cfg_ndbps    = 8'(ndbps);
    cfg_seed     = seed;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input int exp_gap);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    chk("done_latency", cyc - last_out_cyc, 1);
    chk("bit_count", out_cnt, frame_bits);
    chk("queue_empty", exp_q.size(), 0);
    chk("gap_cycles", gap_seen, exp_gap);
    chk("one_load", loads_seen, 1);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_ndbps = '0; cfg_seed = '0;
    byte_data = '0; byte_valid = 1'b0;
    repeat (3) tick();
    chk("rst_valid", scram_valid_i, 0);
    chk("rst_load", scram_load, 0);
    chk("rst_seed", scram_seed, 0);
    chk("rst_flags", {tail_o, sym_last_o, scram_din}, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy_done", {busy, done}, 0);
    sys_rst = 1'b0;
    tick();
    mon_en = 1;

    // 1 byte A5 at 24 bits/symbol: 16+8+6+18 pad = 48 bits
    launch(1, 24, 7'b1011101, 8'hA5, 8'h00, 8'h00);
    wait_done(300, 0);

    // exact fit: last tail bit is also the symbol's last bit
    launch(1, 30, 7'h11, 8'h3C, 8'h00, 8'h00);
    wait_done(300, 0);

    // empty PSDU: the serializer never asks for a byte
    launch(0, 24, 7'h2B, 8'h00, 8'h00, 8'h00);
    wait_done(300, 0);
    chk("len0_no_ready", ready_seen, 0);

    // source stalls 5 cycles when byte 2 is requested
    gap_arm = 1; gap_after = 1; gap_len = 5;
    launch(3, 24, 7'h55, 8'h81, 8'hF0, 8'h6D);
    wait_done(300, 5);

    // zero seed, and a start pulse mid-frame that must be ignored
    launch(2, 36, 7'd0, 8'hC3, 8'h1E, 8'h00);
    repeat (4) tick();
    cfg_len = 12'd7; cfg_ndbps = 8'd48; cfg_seed = 7'h01; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, 0);

    // zero ndbps falls back to 24
    launch(0, 0, 7'h40, 8'h00, 8'h00, 8'h00);
    wait_done(300, 0);

    // reset in the middle of PSDU
    launch(3, 24, 7'h33, 8'h9A, 8'h47, 8'hE2);
    begin
      int n = 0;
      while (out_cnt < 20 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("reach_psdu", out_cnt >= 20, 1);
    mon_en  = 0;
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_valid", {scram_valid_i, scram_load, scram_din}, 0);
    chk("mid_rst_seed", scram_seed, 0);
    chk("mid_rst_flags", {tail_o, sym_last_o}, 0);
    chk("mid_rst_ctrl", {byte_ready, busy, done}, 0);
    src_q.delete();
    exp_q.delete();
    byte_valid = 1'b0;
    xfer_pend  = 0;
    sys_rst    = 1'b0;
    tick();
    prev_valid = 1'b0;
    mon_en     = 1;
    launch(1, 24, 7'b1011101, 8'hA5, 8'h00, 8'h00);
    wait_done(300, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
